board_edit_ctrl: RTL and testbench
==================================

// Module: board_edit_ctrl
// PURPOSE
//   Upstream feeder of Display_top: owns the 18x8 board image (map, 6 bits/cell) and highlight mask (sel_card).
//   Turns mouse clicks into pick / move / highlight edits.
//   Accepts whole-board loads from game/interboard logic. Cell i = row*18+col, row 0 = top.
//   Cell i is map[i*6+5 -: 6] and sel_card[i].
// PARAMETERS
//   COLS        18   board columns
//   ROWS        8    board rows
//   X0          32   board left edge, pixels
//   Y0          80   board top edge, pixels
//   CELL_W      32   cell width, pixels (power of two)
//   CELL_H      40   cell height, pixels (any value)
//   EMPTY_CODE  54   card code meaning "no card"
// PORTS
//   clk             in   1    system clock
//   rst             in   1    synchronous active-high reset
//   interboard_rst  in   1    synchronous reset from peer board; same effect as rst
//   en              in   1    local player may edit (my turn)
//   mouse_x         in   10   cursor x, pixels
//   mouse_y         in   10   cursor y, pixels
//   l_click         in   1    one-cycle left-click pulse
//   r_click         in   1    one-cycle right-click pulse
//   load_en         in   1    one-cycle board load strobe
//   load_map        in   864  board image to load
//   load_sel        in   144  highlight mask to load
//   map             out  864  board image to Display_top
//   sel_card        out  144  highlight mask, 1 = highlighted
//   picked          out  1    a source cell is held
//   picked_idx      out  8    held cell index; valid when picked
//   move_pulse      out  1    one-cycle pulse on a committed move
//   busy            out  1    hit resolution in progress
// BEHAVIOUR
//   Reset (rst or interboard_rst):
//     every map cell = EMPTY_CODE; sel_card = 0; picked = 0; picked_idx = 0; move_pulse = 0; busy = 0; state IDLE.
//   Priority: reset > load_en > FSM.
//   load_en: map <= load_map, sel_card <= load_sel; picked <= 0; state IDLE next cycle.
//     A load aborts any in-flight resolution.
//   Hit resolver:
//     Inputs are latched on start. dx = x-X0, dy = y-Y0; miss if x<X0, y<Y0, col>=COLS or row>=ROWS.
//     col = dx>>log2(CELL_W).
//     row found by repeated subtraction of CELL_H, one subtraction per cycle.
//     hit_valid at most ROWS+2 cycles after start; busy = 1 meanwhile.
//     Clicks arriving while busy=1 are dropped.
//   FSM states: IDLE, HIT_PICK, PICKED, HIT_DROP, HIT_SEL.
//   IDLE:
//     l_click & en -> start resolver, go HIT_PICK.
//     r_click & en -> start resolver, go HIT_SEL.
//     If both arrive together, l_click wins.
//   HIT_PICK on hit_valid:
//     occupied cell -> picked = 1, picked_idx = idx, go PICKED.
//     miss or empty cell -> IDLE.
//   HIT_SEL on hit_valid:
//     occupied cell -> toggle sel_card[idx].
//     In all cases, return to IDLE.
//   PICKED:
//     l_click -> start resolver, go HIT_DROP.
//     r_click -> picked = 0, go IDLE (cancel).
//     en falling -> picked = 0, go IDLE.
//   HIT_DROP on hit_valid:
//     miss -> PICKED (still held).
//     idx == picked_idx -> cancel: picked = 0, go IDLE.
//     empty target -> move:
//       map[dst] <= map[src], map[src] <= EMPTY_CODE;
//       sel[dst] <= sel[src], sel[src] <= 0;
//       move_pulse = 1 for one cycle, picked = 0, go IDLE.
//     occupied other cell -> re-pick: picked_idx = idx, stay PICKED.
//   All map/sel edits take effect on the hit_valid cycle + 1.
//   Untouched cells are never modified.
//   Outputs are registered; no combinational path from inputs to map or sel_card.
// STRUCTURE
//   Shared package board_pkg: COLS, ROWS, EMPTY_CODE, CELL_BITS = 6, MAP_W = 864, state encoding.
//   Sub-module cell_hit_resolver:
//     inputs start, x, y; outputs busy, hit_valid, hit, idx[7:0].
//     Geometry comes from parameters.
//   The top holds the FSM and the map/sel registers.
// TESTING
//   1. Reset -> all 144 cells == 54, sel_card == 0, picked == 0.
//   2. Load cell 0 = 5, rest empty; l_click at (40,90) -> picked == 1, picked_idx == 0 within 10 cycles.
//      Then l_click at (72,130) (cell 19) -> cell19 == 5, cell0 == 54, move_pulse high for exactly 1 cycle.
//   3. Cell 3 occupied; r_click at (136,90) -> sel_card[3] toggles 0->1.
//      Repeat -> sel_card[3] returns to 0.
//      r_click on an empty cell -> no change.
//   4. Cell 0 picked; l_click at (10,10) (miss) -> still picked.
//      l_click on cell 0 again -> picked == 0, map unchanged.
//   5. Second l_click while busy is dropped.
//      load_en asserted mid-resolution -> map == load_map, picked == 0, no move_pulse.
//   6. en = 0 -> clicks ignored.
//      en falls while picked -> picked == 0.
//      interboard_rst mid-PICKED -> full reset values.

Source files
------------

// File: rtl/board_pkg.sv
// Shared board geometry, cell encoding and edit-FSM state encoding.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package board_pkg;

    localparam int COLS      = 18;
    localparam int ROWS      = 8;
    localparam int CELLS     = COLS * ROWS;
    localparam int CELL_BITS = 6;
    localparam int MAP_W     = CELLS * CELL_BITS;   // 864

    localparam logic [CELL_BITS-1:0] EMPTY_CODE = 6'd54;
    localparam logic [MAP_W-1:0]     EMPTY_MAP  = {CELLS{EMPTY_CODE}};

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_HIT_PICK,
        ST_PICKED,
        ST_HIT_DROP,
        ST_HIT_SEL
    } state_t;

    // Bit offset of the lowest bit of cell idx inside the packed map.
    function automatic logic [9:0] cell_lsb(input logic [7:0] idx);
        return 10'(idx) * 10'(CELL_BITS);
    endfunction

endpackage

// File: rtl/cell_hit_resolver.sv
// Maps a pixel position to a board cell index (column by shift, row by repeated subtraction).
// Latency: hit_valid 1..ROWS+1 cycles after the start cycle; busy is high in between.
// Backpressure: start is ignored while busy; abort/rst cancel a resolution with no hit_valid.
//
// Ports:
//   clk, rst          clock, synchronous active-high reset
//   abort             cancel any in-flight resolution
//   start, x, y       begin resolving position (x, y); inputs latched on start
//   busy              resolution in progress
//   hit_valid         one-cycle pulse with the result
//   hit, idx          cell hit flag and cell index (row*COLS+col), 0 on miss
module cell_hit_resolver #(
    parameter int X0     = 32,
    parameter int Y0     = 80,
    parameter int CELL_W = 32,
    parameter int CELL_H = 40,
    parameter int COLS   = 18,
    parameter int ROWS   = 8
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       abort,
    input  logic       start,
    input  logic [9:0] x,
    input  logic [9:0] y,
    output logic       busy,
    output logic       hit_valid,
    output logic       hit,
    output logic [7:0] idx
);

    localparam int SHIFT = $clog2(CELL_W);
    localparam int RW    = $clog2(ROWS + 1);

    localparam logic [9:0]    X0_V   = 10'(X0);
    localparam logic [9:0]    Y0_V   = 10'(Y0);
    localparam logic [9:0]    CH_V   = 10'(CELL_H);
    localparam logic [9:0]    COLS_V = 10'(COLS);
    localparam logic [7:0]    COLS_8 = 8'(COLS);
    localparam logic [RW-1:0] ROWS_V = RW'(ROWS);

    logic [9:0]    dx;
    logic [9:0]    dy;
    logic [9:0]    col_full;
    logic          early_miss;

    logic [9:0]    rem;
    logic [RW-1:0] row;
    logic [7:0]    col;
    logic          miss;

    // Column and left/top/right misses are known immediately; only the row needs iterating.
    assign dx         = x - X0_V;
    assign dy         = y - Y0_V;
    assign col_full   = dx >> SHIFT;
    assign early_miss = (x < X0_V) || (y < Y0_V) || (col_full >= COLS_V);

    always_ff @(posedge clk) begin
        if (rst || abort) begin
            busy      <= 1'b0;
            hit_valid <= 1'b0;
            hit       <= 1'b0;
            idx       <= '0;
            rem       <= '0;
            row       <= '0;
            col       <= '0;
            miss      <= 1'b0;
        end else begin
            hit_valid <= 1'b0;
            if (busy) begin
                if (miss || row == ROWS_V) begin
                    // Off-board: either known at start or subtracted past the last row.
                    hit_valid <= 1'b1;
                    hit       <= 1'b0;
                    idx       <= '0;
                    busy      <= 1'b0;
                end else if (rem < CH_V) begin
                    hit_valid <= 1'b1;
                    hit       <= 1'b1;
                    idx       <= 8'(row) * COLS_8 + col;
                    busy      <= 1'b0;
                end else begin
                    rem <= rem - CH_V;
                    row <= row + 1'b1;
                end
            end else if (start) begin
                busy <= 1'b1;
                rem  <= dy;
                row  <= '0;
                col  <= col_full[7:0];
                miss <= early_miss;
            end
        end
    end

endmodule

// File: rtl/board_edit_ctrl.sv
// Owns the board image and highlight mask; turns clicks into pick/move/highlight edits and whole-board loads.
// Latency: edits land one cycle after the resolver's hit_valid; loads land the cycle after load_en.
// Backpressure: clicks are dropped while a hit resolution is in flight (busy); load_en aborts it.
//
// Ports:
//   clk, rst, interboard_rst   clock and two equivalent synchronous active-high resets
//   en                         local player may edit
//   mouse_x, mouse_y           cursor position in pixels
//   l_click, r_click           one-cycle click pulses
//   load_en, load_map, load_sel  whole-board load strobe and data
//   map, sel_card              registered board image (6 bits/cell) and highlight mask
//   picked, picked_idx         a source cell is held, and which
//   move_pulse                 one-cycle pulse per committed move
//   busy                       hit resolution in progress
module board_edit_ctrl
    import board_pkg::*;
#(
    parameter int X0     = 32,
    parameter int Y0     = 80,
    parameter int CELL_W = 32,
    parameter int CELL_H = 40
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             interboard_rst,
    input  logic             en,
    input  logic [9:0]       mouse_x,
    input  logic [9:0]       mouse_y,
    input  logic             l_click,
    input  logic             r_click,
    input  logic             load_en,
    input  logic [MAP_W-1:0] load_map,
    input  logic [CELLS-1:0] load_sel,
    output logic [MAP_W-1:0] map,
    output logic [CELLS-1:0] sel_card,
    output logic             picked,
    output logic [7:0]       picked_idx,
    output logic             move_pulse,
    output logic             busy
);

    state_t               state;
    logic                 rst_any;
    logic                 start;
    logic                 hit_valid;
    logic                 hit;
    logic [7:0]           hit_idx;
    logic [CELL_BITS-1:0] hit_cell;
    logic [CELL_BITS-1:0] src_cell;
    logic                 hit_occ;

    assign rst_any = rst || interboard_rst;

    // Resolver start must mirror the IDLE/PICKED transitions below exactly.
    assign start = !rst_any && !load_en && en &&
                   (((state == ST_IDLE) && (l_click || r_click)) ||
                    ((state == ST_PICKED) && l_click));

    assign hit_cell = map[cell_lsb(hit_idx) +: CELL_BITS];
    assign src_cell = map[cell_lsb(picked_idx) +: CELL_BITS];
    assign hit_occ  = (hit_cell != EMPTY_CODE);

    cell_hit_resolver #(
        .X0     (X0),
        .Y0     (Y0),
        .CELL_W (CELL_W),
        .CELL_H (CELL_H),
        .COLS   (COLS),
        .ROWS   (ROWS)
    ) u_hit (
        .clk       (clk),
        .rst       (rst_any),
        .abort     (load_en),
        .start     (start),
        .x         (mouse_x),
        .y         (mouse_y),
        .busy      (busy),
        .hit_valid (hit_valid),
        .hit       (hit),
        .idx       (hit_idx)
    );

    always_ff @(posedge clk) begin
        if (rst_any) begin
            map        <= EMPTY_MAP;
            sel_card   <= '0;
            picked     <= 1'b0;
            picked_idx <= '0;
            move_pulse <= 1'b0;
            state      <= ST_IDLE;
        end else begin
            move_pulse <= 1'b0;
            if (load_en) begin
                map      <= load_map;
                sel_card <= load_sel;
                picked   <= 1'b0;
                state    <= ST_IDLE;
            end else begin
                case (state)
                    ST_IDLE: begin
                        if (en && l_click) begin
                            state <= ST_HIT_PICK;
                        end else if (en && r_click) begin
                            state <= ST_HIT_SEL;
                        end
                    end
                    ST_HIT_PICK: begin
                        if (hit_valid) begin
                            if (hit && hit_occ) begin
                                picked     <= 1'b1;
                                picked_idx <= hit_idx;
                                state      <= ST_PICKED;
                            end else begin
                                state <= ST_IDLE;
                            end
                        end
                    end
                    ST_HIT_SEL: begin
                        if (hit_valid) begin
                            if (hit && hit_occ) begin
                                sel_card[hit_idx] <= ~sel_card[hit_idx];
                            end
                            state <= ST_IDLE;
                        end
                    end
                    ST_PICKED: begin
                        if (!en) begin
                            picked <= 1'b0;
                            state  <= ST_IDLE;
                        end else if (l_click) begin
                            state <= ST_HIT_DROP;
                        end else if (r_click) begin
                            picked <= 1'b0;
                            state  <= ST_IDLE;
                        end
                    end
                    ST_HIT_DROP: begin
                        if (hit_valid) begin
                            if (!hit) begin
                                state <= ST_PICKED;
                            end else if (hit_idx == picked_idx) begin
                                picked <= 1'b0;
                                state  <= ST_IDLE;
                            end else if (!hit_occ) begin
                                // Move: card and its highlight travel together, source is vacated.
                                map[cell_lsb(hit_idx) +: CELL_BITS]    <= src_cell;
                                map[cell_lsb(picked_idx) +: CELL_BITS] <= EMPTY_CODE;
                                sel_card[hit_idx]                      <= sel_card[picked_idx];
                                sel_card[picked_idx]                   <= 1'b0;
                                move_pulse                             <= 1'b1;
                                picked                                 <= 1'b0;
                                state                                  <= ST_IDLE;
                            end else begin
                                picked_idx <= hit_idx;
                                state      <= ST_PICKED;
                            end
                        end
                    end
                    default: state <= ST_IDLE;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_board_edit_ctrl.sv
// Scoreboard bench for board_edit_ctrl: each resolving click pushes its expected result,
// a negedge monitor pops and compares when the edit lands (cycle after hit_valid).
// Directed checks cover reset, loads, en gating and cancels that produce no resolution.
module tb_board_edit_ctrl;

    logic         clk;
    logic         rst;
    logic         interboard_rst;
    logic         en;
    logic [9:0]   mouse_x;
    logic [9:0]   mouse_y;
    logic         l_click;
    logic         r_click;
    logic         load_en;
    logic [863:0] load_map;
    logic [143:0] load_sel;
    logic [863:0] map;
    logic [143:0] sel_card;
    logic         picked;
    logic [7:0]   picked_idx;
    logic         move_pulse;
    logic         busy;

    board_edit_ctrl dut (
        .clk            (clk),
        .rst            (rst),
        .interboard_rst (interboard_rst),
        .en             (en),
        .mouse_x        (mouse_x),
        .mouse_y        (mouse_y),
        .l_click        (l_click),
        .r_click        (r_click),
        .load_en        (load_en),
        .load_map       (load_map),
        .load_sel       (load_sel),
        .map            (map),
        .sel_card       (sel_card),
        .picked         (picked),
        .picked_idx     (picked_idx),
        .move_pulse     (move_pulse),
        .busy           (busy)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    typedef struct {
        int id;
        int pk;
        int pidx;
        int mp;
        int ca;
        int va;
        int cb;
        int vb;
        int cs;
        int vs;
    } exp_t;

    exp_t q[$];
    int   n_assert = 0;
    int   n_fail   = 0;
    int   stray    = 0;
    int   next_id  = 0;
    logic [863:0] empty_m;

    task automatic chk(input string nm, input int act, input int exp);
        n_assert++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", nm, act, exp);
        end
    endtask

    function automatic int dcell(input int i);
        return int'(map[10'(i * 6) +: 6]);
    endfunction

    function automatic logic [863:0] put(input logic [863:0] m, input int i, input logic [5:0] v);
        logic [863:0] r;
        r = m;
        r[10'(i * 6) +: 6] = v;
        return r;
    endfunction

    function automatic int map_diff(input logic [863:0] e);
        int d = 0;
        for (int i = 0; i < 144; i++) begin
            if (map[10'(i * 6) +: 6] != e[10'(i * 6) +: 6]) d++;
        end
        return d;
    endfunction

    task automatic push(input int pk, input int pidx, input int mp, input int ca, input int va,
                        input int cb, input int vb, input int cs, input int vs);
        exp_t e;
        e.id = next_id; e.pk = pk; e.pidx = pidx; e.mp = mp;
        e.ca = ca; e.va = va; e.cb = cb; e.vb = vb; e.cs = cs; e.vs = vs;
        next_id++;
        q.push_back(e);
    endtask

    // Monitor: the edit for a resolution is visible the cycle after hit_valid.
    initial begin
        logic hv_prev;
        exp_t e;
        hv_prev = 1'b0;
        forever begin
            @(negedge clk);
            if (hv_prev) begin
                if (q.size() == 0) begin
                    chk("unexpected resolution", 1, 0);
                end else begin
                    e = q.pop_front();
                    chk($sformatf("r%0d picked", e.id), int'(picked), e.pk);
                    if (e.pk != 0) chk($sformatf("r%0d picked_idx", e.id), int'(picked_idx), e.pidx);
                    chk($sformatf("r%0d move_pulse", e.id), int'(move_pulse), e.mp);
                    chk($sformatf("r%0d cell%0d", e.id, e.ca), dcell(e.ca), e.va);
                    chk($sformatf("r%0d cell%0d", e.id, e.cb), dcell(e.cb), e.vb);
                    chk($sformatf("r%0d sel%0d", e.id, e.cs), int'(sel_card[e.cs]), e.vs);
                end
            end else if (move_pulse) begin
                stray++;
            end
            hv_prev = dut.u_hit.hit_valid;
        end
    end

    task automatic wait_idle(input string nm);
        int n;
        n = 0;
        while (busy && n < 10) begin
            @(posedge clk); #1;
            n++;
        end
        if (busy) chk({nm, " resolve timeout"}, 1, 0);
        repeat (3) @(posedge clk);
        #1;
    endtask

    task automatic click(input bit l, input bit r, input int x, input int y);
        @(posedge clk); #1;
        mouse_x = 10'(x); mouse_y = 10'(y); l_click = l; r_click = r;
        @(posedge clk); #1;
        l_click = 1'b0; r_click = 1'b0;
        wait_idle($sformatf("click(%0d,%0d)", x, y));
    endtask

    task automatic load(input logic [863:0] m, input logic [143:0] s);
        @(posedge clk); #1;
        load_map = m; load_sel = s; load_en = 1'b1;
        @(posedge clk); #1;
        load_en = 1'b0;
    endtask

    task automatic pulse_then_check_picked(input string nm);
        chk(nm, int'(picked), 0);
    endtask

    logic [863:0] m;
    logic [863:0] m2;
    logic [143:0] s;
    logic [143:0] s2;

    initial begin
        empty_m = {144{6'd54}};
        rst = 1'b1; interboard_rst = 1'b0; en = 1'b0;
        mouse_x = '0; mouse_y = '0; l_click = 1'b0; r_click = 1'b0;
        load_en = 1'b0; load_map = '0; load_sel = '0;
        repeat (3) @(posedge clk);
        #1;
        // 1. reset state
        chk("reset map diff", map_diff(empty_m), 0);
        chk("reset sel", int'(sel_card != '0), 0);
        chk("reset picked", int'(picked), 0);
        chk("reset picked_idx", int'(picked_idx), 0);
        chk("reset move_pulse", int'(move_pulse), 0);
        chk("reset busy", int'(busy), 0);
        rst = 1'b0;

        // 2. pick cell 0, move to cell 19
        m = put(empty_m, 0, 6'd5);
        load(m, '0);
        chk("load map diff", map_diff(m), 0);
        en = 1'b1;
        push(1, 0, 0, 0, 5, 19, 54, 0, 0);
        click(1, 0, 40, 90);
        push(0, 0, 1, 19, 5, 0, 54, 19, 0);
        click(1, 0, 72, 130);

        // 3. highlight toggles on occupied cell 3, none on empty cell 4
        m = put(empty_m, 3, 6'd7);
        load(m, '0);
        push(0, 0, 0, 3, 7, 3, 7, 3, 1);
        click(0, 1, 136, 90);
        push(0, 0, 0, 3, 7, 3, 7, 3, 0);
        click(0, 1, 136, 90);
        push(0, 0, 0, 4, 54, 3, 7, 4, 0);
        click(0, 1, 168, 90);

        // 4. misses, cancel, re-pick, move to last cell
        m = put(put(empty_m, 0, 6'd5), 1, 6'd9);
        s = '0; s[1] = 1'b1;
        load(m, s);
        push(1, 0, 0, 0, 5, 1, 9, 1, 1);
        click(1, 0, 40, 90);
        push(1, 0, 0, 0, 5, 1, 9, 0, 0);
        click(1, 0, 10, 10);
        push(0, 0, 0, 0, 5, 1, 9, 0, 0);
        click(1, 0, 40, 90);
        push(0, 0, 0, 0, 5, 1, 9, 1, 1);
        click(1, 0, 608, 90);
        push(1, 0, 0, 0, 5, 1, 9, 0, 0);
        click(1, 0, 40, 90);
        push(1, 1, 0, 0, 5, 1, 9, 1, 1);
        click(1, 0, 72, 90);
        push(1, 1, 0, 1, 9, 143, 54, 1, 1);
        click(1, 0, 40, 400);
        push(0, 0, 1, 143, 9, 1, 54, 143, 1);
        click(1, 0, 579, 365);
        chk("moved sel src cleared", int'(sel_card[1]), 0);

        // 5. second click while busy is dropped; load aborts a drop in flight
        m = put(empty_m, 54, 6'd5);
        load(m, '0);
        push(1, 54, 0, 54, 5, 19, 54, 54, 0);
        @(posedge clk); #1;
        mouse_x = 10'd40; mouse_y = 10'd210; l_click = 1'b1;
        @(posedge clk); #1;
        mouse_x = 10'd72; mouse_y = 10'd130;
        @(posedge clk); #1;
        l_click = 1'b0;
        wait_idle("dropped click");
        m2 = put(empty_m, 5, 6'd3);
        s2 = '0; s2[7] = 1'b1;
        @(posedge clk); #1;
        mouse_x = 10'd40; mouse_y = 10'd365; l_click = 1'b1;
        @(posedge clk); #1;
        l_click = 1'b0;
        @(posedge clk); #1;
        load(m2, s2);
        chk("abort load map diff", map_diff(m2), 0);
        chk("abort load sel", int'(sel_card == s2), 1);
        chk("abort load picked", int'(picked), 0);
        chk("abort load busy", int'(busy), 0);
        repeat (12) @(posedge clk);
        #1;

        // 6. en gating, cancels, interboard reset
        en = 1'b0;
        mouse_x = 10'd196; mouse_y = 10'd90; l_click = 1'b1;
        @(posedge clk); #1;
        l_click = 1'b0;
        chk("en0 l_click busy", int'(busy), 0);
        r_click = 1'b1;
        @(posedge clk); #1;
        r_click = 1'b0;
        chk("en0 r_click busy", int'(busy), 0);
        repeat (3) @(posedge clk);
        #1;
        chk("en0 picked", int'(picked), 0);
        chk("en0 sel5", int'(sel_card[5]), 0);
        en = 1'b1;
        push(1, 5, 0, 5, 3, 5, 3, 5, 0);
        click(1, 1, 196, 90);
        r_click = 1'b1;
        @(posedge clk); #1;
        r_click = 1'b0;
        chk("r_click cancel picked", int'(picked), 0);
        chk("r_click cancel busy", int'(busy), 0);
        push(1, 5, 0, 5, 3, 5, 3, 5, 0);
        click(1, 0, 196, 90);
        en = 1'b0;
        @(posedge clk); #1;
        en = 1'b1;
        chk("en fall picked", int'(picked), 0);
        push(1, 5, 0, 5, 3, 5, 3, 5, 0);
        click(1, 0, 196, 90);
        interboard_rst = 1'b1;
        @(posedge clk); #1;
        interboard_rst = 1'b0;
        chk("ib_rst map diff", map_diff(empty_m), 0);
        chk("ib_rst sel", int'(sel_card != '0), 0);
        chk("ib_rst picked", int'(picked), 0);
        chk("ib_rst picked_idx", int'(picked_idx), 0);
        chk("ib_rst busy", int'(busy), 0);

        repeat (5) @(posedge clk);
        #1;
        chk("pending expectations", q.size(), 0);
        chk("stray move_pulse", stray, 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
        $fatal(1);
    end

endmodule
